// File: rtl/pdm_capture_seq.sv
// pdm_capture_seq: runs back-to-back PDM capture frames with optional gaps, abort and timeouts.
module pdm_capture_seq #(
    parameter int CNT_W    = 16,
    parameter int START_TO = 64,
    parameter int CAP_TO   = 1048576,
    parameter int TO_W     = 21
) (
    input  logic             g_hclk_es1,
    input  logic             hreset_n,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             irq_clr,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic             core_bsy,
    output logic [1:0]       core_ctrl,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             active,
    output logic             done_flag,
    output logic             err_flag,
    output logic             irq,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_BSY, CAPTURE, GAP, ABORT, DONE, ERR} state_t;
    localparam logic [TO_W-1:0] START_LIM = TO_W'(START_TO - 1);
    localparam logic [TO_W-1:0] CAP_LIM   = TO_W'(CAP_TO - 1);
    state_t           state, nxt;
    logic [TO_W-1:0]  cnt;
    logic [CNT_W-1:0] frames_tgt, gap_len;
    logic             idle_like, start, frame_end, last, set_done, set_err, enter_abort;
    assign state_o = state;
    assign active  = !idle_like;
    always_comb begin
        idle_like   = state inside {IDLE, DONE, ERR};
        start       = cmd_start && idle_like;
        frame_end   = state == CAPTURE && !core_bsy && !cmd_abort;
        last        = (CNT_W+1)'(frame_cnt) + (CNT_W+1)'(1) == (CNT_W+1)'(frames_tgt);
        nxt         = state;
        if (idle_like) begin
            if (cmd_start) nxt = ARM;
        end else if (cmd_abort && state != ABORT) begin
            nxt = ABORT;
        end else begin
            case (state)
                ARM:      nxt = WAIT_BSY;
                WAIT_BSY: nxt = core_bsy ? CAPTURE : (cnt == START_LIM ? ERR : WAIT_BSY);
                CAPTURE:  nxt = !core_bsy ? (last ? DONE : (gap_len == '0 ? ARM : GAP))
                                          : (cnt == CAP_LIM ? ERR : CAPTURE);
                GAP:      nxt = cnt == TO_W'(gap_len) - TO_W'(1) ? ARM : GAP;
                ABORT:    nxt = !core_bsy ? DONE : (cnt == CAP_LIM ? ERR : ABORT);
                default:  nxt = state;
            endcase
        end
        set_done    = nxt == DONE && state != DONE;
        set_err     = nxt == ERR && state != ERR;
        enter_abort = nxt == ABORT && state != ABORT;
    end
    // One counter serves start/capture/abort timeouts and the gap length; it restarts on every state change.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            core_ctrl  <= 2'b00;
            frames_tgt <= '0;
            gap_len    <= '0;
            frame_cnt  <= '0;
            done_flag  <= 1'b0;
            err_flag   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= (nxt != state || idle_like) ? '0 : cnt + TO_W'(1);
            core_ctrl  <= nxt == ARM ? 2'b01 : ((set_err || enter_abort) ? 2'b10 : 2'b00);
            frames_tgt <= start ? (cfg_frames == '0 ? CNT_W'(1) : cfg_frames) : frames_tgt;
            gap_len    <= start ? cfg_gap : gap_len;
            frame_cnt  <= start ? '0 : ((frame_end && !(&frame_cnt)) ? frame_cnt + CNT_W'(1) : frame_cnt);
            done_flag  <= set_done ? 1'b1 : ((start || irq_clr) ? 1'b0 : done_flag);
            err_flag   <= set_err ? 1'b1 : ((start || irq_clr) ? 1'b0 : err_flag);
            irq        <= (set_done || set_err) ? 1'b1 : ((start || irq_clr) ? 1'b0 : irq);
        end
    end
endmodule

// File: tb/tb_pdm_capture_seq.sv
// tb_pdm_capture_seq: drives the sequencer against a simple behavioural capture core and checks timing/flags.
module tb_pdm_capture_seq;
    localparam int CNT_W    = 16;
    localparam int START_TO = 64;
    localparam int CAP_TO   = 300;
    logic             g_hclk_es1, hreset_n, cmd_start, cmd_abort, irq_clr, core_bsy;
    logic [CNT_W-1:0] cfg_frames, cfg_gap, frame_cnt;
    logic [1:0]       core_ctrl;
    logic             active, done_flag, err_flag, irq;
    logic [2:0]       state_o;
    int checks, errors, cyc, n01, n10, n11;
    int bsy_d, bsy_l, stop_d, rise_cnt, hold_cnt;
    bit core_dead;

    pdm_capture_seq #(.CNT_W(CNT_W), .START_TO(START_TO), .CAP_TO(CAP_TO), .TO_W(21)) dut (
        .g_hclk_es1(g_hclk_es1), .hreset_n(hreset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .irq_clr(irq_clr), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap), .core_bsy(core_bsy),
        .core_ctrl(core_ctrl), .frame_cnt(frame_cnt), .active(active), .done_flag(done_flag),
        .err_flag(err_flag), .irq(irq), .state_o(state_o));

    initial g_hclk_es1 = 1'b0;
    always #5 g_hclk_es1 = ~g_hclk_es1;

    // Behavioural core: bsy rises bsy_d cycles after a start command, holds bsy_l cycles, drops stop_d after a stop.
    always @(negedge g_hclk_es1) begin
        if (!hreset_n) begin
            rise_cnt = 0;
            hold_cnt = 0;
            core_bsy = 1'b0;
        end else begin
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) begin
                    core_bsy = 1'b1;
                    hold_cnt = bsy_l;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) core_bsy = 1'b0;
            end
            if (core_ctrl == 2'b01 && !core_dead) rise_cnt = bsy_d;
            if (core_ctrl == 2'b10 && core_bsy) hold_cnt = stop_d;
            if (core_ctrl == 2'b01) n01++;
            if (core_ctrl == 2'b10) n10++;
            if (core_ctrl == 2'b11) n11++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_core(input int d, input int l, input int s);
        bsy_d = d;
        bsy_l = l;
        stop_d = s;
    endtask

    task automatic start_seq(input int f, input int g);
        cfg_frames = CNT_W'(f);
        cfg_gap = CNT_W'(g);
        n01 = 0;
        n10 = 0;
        cmd_start = 1'b1;
        @(negedge g_hclk_es1);
        cmd_start = 1'b0;
        cyc = 0;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge g_hclk_es1);
            cyc++;
        end
    endtask

    task automatic wait_end(input int budget);
        while (!(state_o == 3'd6 || state_o == 3'd7) && cyc < budget) begin
            @(negedge g_hclk_es1);
            cyc++;
        end
        chk("end_reached", 32'(state_o == 3'd6 || state_o == 3'd7), 1);
    endtask

    task automatic check_done(input string tag, input int exp_cyc, input int exp_fc, input int exp_p01);
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_frame_cnt"}, frame_cnt, exp_fc);
        chk({tag, "_pulses01"}, n01, exp_p01);
        chk({tag, "_pulses10"}, n10, 0);
        chk({tag, "_state"}, state_o, 6);
        chk({tag, "_flags"}, {active, done_flag, err_flag, irq}, 4'b0101);
    endtask

    function automatic int ref_cycles(input int f, input int g, input int d, input int l);
        int n = (f == 0) ? 1 : f;
        return n * (d + l + 1) + (n - 1) * g;
    endfunction

    typedef struct {int frames; int gap; int d; int l; int cyc; int fc; int p01;} vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{3, 0, 2, 10, 39, 3, 3};
        tbl[1] = '{2, 5, 2, 10, 31, 2, 2};
        tbl[2] = '{0, 0, 1, 1, 3, 1, 1};
        tbl[3] = '{1, 3, 3, 4, 8, 1, 1};
        tbl[4] = '{4, 1, 1, 2, 19, 4, 4};
        checks = 0; errors = 0; n11 = 0;
        hreset_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; irq_clr = 1'b0;
        cfg_frames = '0; cfg_gap = '0; core_dead = 1'b0;
        set_core(2, 10, 3);
        repeat (3) @(negedge g_hclk_es1);
        chk("reset_state", state_o, 0);
        chk("reset_outs", {core_ctrl, active, done_flag, err_flag, irq}, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        hreset_n = 1'b1;
        @(negedge g_hclk_es1);

        for (int i = 0; i < 5; i++) begin
            set_core(tbl[i].d, tbl[i].l, 3);
            start_seq(tbl[i].frames, tbl[i].gap);
            wait_end(2000);
            check_done($sformatf("tbl%0d", i), tbl[i].cyc, tbl[i].fc, tbl[i].p01);
        end

        for (int i = 0; i < 25; i++) begin
            int f, g, d, l;
            f = $urandom_range(0, 5);
            g = $urandom_range(0, 6);
            d = $urandom_range(1, 5);
            l = $urandom_range(1, 8);
            set_core(d, l, 3);
            start_seq(f, g);
            wait_end(2000);
            check_done($sformatf("rnd%0d", i), ref_cycles(f, g, d, l), (f == 0) ? 1 : f, (f == 0) ? 1 : f);
        end

        core_dead = 1'b1;
        start_seq(2, 0);
        wait_end(2000);
        chk("start_to_cycles", cyc, 1 + START_TO);
        repeat (3) @(negedge g_hclk_es1);
        chk("start_to_state", state_o, 7);
        chk("start_to_flags", {active, done_flag, err_flag, irq}, 4'b0011);
        chk("start_to_fc", frame_cnt, 0);
        chk("start_to_p10", n10, 1);
        core_dead = 1'b0;

        set_core(2, 100000, 2);
        start_seq(2, 0);
        wait_end(2000);
        chk("cap_to_cycles", cyc, 3 + CAP_TO);
        repeat (4) @(negedge g_hclk_es1);
        chk("cap_to_state", state_o, 7);
        chk("cap_to_p10", n10, 1);
        chk("cap_to_bsy_dropped", core_bsy, 0);

        set_core(2, 10, 3);
        start_seq(4, 0);
        step_to(18);
        cmd_start = 1'b1;
        @(negedge g_hclk_es1); cyc++;
        cmd_start = 1'b0;
        step_to(20);
        cmd_abort = 1'b1;
        @(negedge g_hclk_es1); cyc++;
        cmd_abort = 1'b0;
        chk("abort_ctrl", core_ctrl, 2);
        wait_end(2000);
        chk("abort_cycles", cyc, 25);
        chk("abort_state", state_o, 6);
        chk("abort_fc", frame_cnt, 1);
        chk("abort_p01", n01, 2);
        chk("abort_p10", n10, 1);
        chk("abort_flags", {done_flag, err_flag, irq}, 3'b101);

        set_core(1, 1, 3);
        start_seq(1, 0);
        step_to(2);
        irq_clr = 1'b1;
        @(negedge g_hclk_es1); cyc++;
        irq_clr = 1'b0;
        chk("clr_setwins_state", state_o, 6);
        chk("clr_setwins_irq", {done_flag, irq}, 2'b11);
        irq_clr = 1'b1;
        @(negedge g_hclk_es1);
        irq_clr = 1'b0;
        chk("clr_later", {done_flag, err_flag, irq}, 0);
        chk("clr_later_state", state_o, 6);

        start_seq(1, 0);
        wait_end(2000);
        cmd_start = 1'b1;
        irq_clr = 1'b1;
        @(negedge g_hclk_es1);
        cmd_start = 1'b0;
        irq_clr = 1'b0;
        cyc = 0;
        chk("start_clr_state", state_o, 1);
        chk("start_clr_flags", {active, done_flag, irq}, 3'b100);
        wait_end(2000);
        chk("start_clr_done", {done_flag, irq}, 2'b11);

        start_seq(2, 6);
        step_to(5);
        chk("gap_state", state_o, 4);
        #2 hreset_n = 1'b0;
        #1;
        chk("async_rst_state", state_o, 0);
        chk("async_rst_fc", frame_cnt, 0);
        chk("async_rst_outs", {core_ctrl, active, done_flag, err_flag, irq}, 0);
        @(negedge g_hclk_es1);
        hreset_n = 1'b1;
        @(negedge g_hclk_es1);
        chk("post_rst_idle", state_o, 0);
        chk("never_ctrl11", n11, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdm_capture_seq.md
Name: pdm_capture_seq

Overview:
Sequencer that drives the PDM capture core's 2-bit control input and monitors its busy flag. It runs a software-programmed number of capture frames back to back, with an optional idle gap between frames, and supports abort. It reports progress, completion and timeout errors to the AHB register file, which owns the command/config registers. It sits between the AHB slave register decode and the PDM capture core; everything is clocked on the AHB clock.

Parameters:
CNT_W, 16, width of frame count, gap length and frame counter
START_TO, 64, max cycles from start pulse to core bsy rising
CAP_TO, 1048576, max cycles bsy may stay high in one frame
TO_W, 21, width of the timeout counter; must hold CAP_TO

Ports:
g_hclk_es1  in  1  AHB clock, sole clock
hreset_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle pulse: begin sequence (ignored unless IDLE, DONE or ERR)
cmd_abort  in  1  one-cycle pulse: abort the running sequence
irq_clr  in  1  one-cycle pulse: clear irq, done_flag and err_flag
cfg_frames  in  CNT_W  frames to capture; 0 means 1
cfg_gap  in  CNT_W  idle cycles between frames
core_bsy  in  1  capture core busy flag
core_ctrl  out  2  to core: 00 nop, 01 start frame, 10 stop, 11 reserved (never driven)
frame_cnt  out  CNT_W  frames completed in the current sequence
active  out  1  high in every state except IDLE, DONE and ERR
done_flag  out  1  sticky; sequence completed normally or by abort
err_flag  out  1  sticky; timeout occurred
irq  out  1  sticky; set with done_flag or err_flag
state_o  out  3  current state encoding, for the status register

Behaviour:
- Reset values: state IDLE, core_ctrl=00, frame_cnt=0, all flags=0, irq=0, counters=0.
- Registered outputs; core_ctrl is asserted for exactly one cycle per command.
- State encodings: IDLE=0, ARM=1, WAIT_BSY=2, CAPTURE=3, GAP=4, ABORT=5, DONE=6, ERR=7.
- IDLE/DONE/ERR on cmd_start:
  - latch frames_tgt = max(cfg_frames,1) and gap_len = cfg_gap;
  - clear frame_cnt, done_flag, err_flag, irq;
  - go to ARM.
- ARM (1 cycle): core_ctrl=01; load to_cnt=0; go to WAIT_BSY.
- WAIT_BSY:
  - if core_bsy=1, go to CAPTURE and reset to_cnt;
  - else to_cnt++; when to_cnt reaches START_TO-1, go to ERR.
- CAPTURE:
  - if core_bsy=0, frame_cnt++;
    - if frame_cnt+1 == frames_tgt, go to DONE;
    - else if gap_len=0, go to ARM;
    - else go to GAP with gap counter=0.
  - else to_cnt++; when to_cnt reaches CAP_TO-1, go to ERR.
- GAP: gap counter++; when it equals gap_len-1, go to ARM. The gap therefore lasts exactly gap_len cycles.
- ABORT:
  - entered from ARM, WAIT_BSY, CAPTURE or GAP when cmd_abort=1; abort has priority over every other transition that cycle.
  - Drive core_ctrl=10 on the entry cycle only.
  - Wait for core_bsy=0, then go to DONE. frame_cnt is not incremented for the aborted frame.
  - If core_bsy is still 1 after CAP_TO cycles, go to ERR.
- DONE entry: set done_flag=1 and irq=1. Hold until cmd_start.
- ERR entry: set err_flag=1 and irq=1; drive core_ctrl=10 for one cycle to stop the core. Hold until cmd_start.
- Command handling:
  - cmd_start while active: ignored.
  - cmd_abort while IDLE, DONE or ERR: ignored.
  - irq_clr: clears irq, done_flag and err_flag unless a set event occurs in the same cycle; set wins.
  - cmd_start and irq_clr in the same cycle in DONE: start proceeds and flags end at 0.
- frame_cnt saturates at all-ones and never wraps.
- Timeout counters are TO_W bits and are cleared on every state entry.
- Asynchronous reset mid-sequence returns to the reset values immediately. No stop command is issued to the core; the core shares hreset_n.

Test Plan:
- Reset, then cfg_frames=3, cfg_gap=0, cmd_start; model core asserts bsy 2 cycles after each 01 pulse and holds it 10 cycles -> exactly three 01 pulses, frame_cnt=3, done_flag=1, irq=1, state_o=6, active=0.
- cfg_frames=2, cfg_gap=5 -> measured cycles from bsy falling to the next 01 pulse = 5 (GAP) + 1 (ARM) = 6; frame_cnt ends at 2.
- Core never raises bsy -> ERR exactly START_TO cycles after the WAIT_BSY entry; one 10 pulse; err_flag=1, irq=1, frame_cnt=0.
- cmd_abort mid-CAPTURE of frame 2 of 4, core drops bsy 3 cycles later -> one 10 pulse, DONE reached, frame_cnt=1, done_flag=1.
- irq_clr on the same cycle as DONE entry -> irq=1 (set wins); irq_clr one cycle later -> irq=0, done_flag=0.
- cmd_start while in CAPTURE -> ignored, no extra 01 pulse. hreset_n low mid-GAP -> all outputs return to reset values on the same edge.
